// File: rtl/marquee_ctrl.sv
// marquee_ctrl: moves a short digit pattern across a row of 7-seg digits (scroll, bounce, hold).
// Optional hold-mode blink is compiled in when MARQUEE_BLINK_EN is defined.
module marquee_ctrl #(
    parameter int                   DIGITS   = 4,
    parameter int                   PAT_LEN  = 2,
    parameter logic [4*PAT_LEN-1:0] PATTERN  = {4'd2, 4'd5},
    parameter int                   TICK_DIV = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            led,
    output logic                  tick
);

    typedef enum logic [1:0] {
        M_RIGHT  = 2'b00,
        M_BOUNCE = 2'b01,
        M_LEFT   = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    localparam int PW = $clog2(DIGITS);
    localparam int CW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] POS_LAST   = PW'(DIGITS - 1);
    localparam logic [PW-1:0] BOUNCE_MAX = PW'(DIGITS - PAT_LEN);
    localparam logic [CW-1:0] CNT_MAX    = CW'(TICK_DIV - 1);

    mode_e              mode_q;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      pos, pos_nxt;
    logic               dir, dir_nxt;
    logic [4*DIGITS-1:0] bcd_nxt;
`ifdef MARQUEE_BLINK_EN
    logic               blink, blink_nxt;
`endif

    // Digit i shows pattern digit (i - p) mod DIGITS when that index lies inside the pattern.
    function automatic logic [4*DIGITS-1:0] render(input logic [PW-1:0] p);
        logic [4*DIGITS-1:0] r;
        int k;
        r = '1;
        for (int i = 0; i < DIGITS; i++) begin
            k = i - int'(p);
            if (k < 0) k = k + DIGITS;
            if (k < PAT_LEN) r[4*(DIGITS-1-i) +: 4] = PATTERN[4*(PAT_LEN-1-k) +: 4];
        end
        return r;
    endfunction

    assign mode_q = mode_e'(mode);
    assign tick   = en && !rst && (cnt == CNT_MAX);

    always_comb begin
        case (mode_q)
            M_RIGHT:  led = 3'b100;
            M_BOUNCE: led = 3'b010;
            M_LEFT:   led = 3'b001;
            default:  led = 3'b110;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
`ifdef MARQUEE_BLINK_EN
        blink_nxt = 1'b0;
`endif
        case (mode_q)
            M_RIGHT: begin
                dir_nxt = 1'b0;
                if (tick) pos_nxt = (pos == POS_LAST) ? '0 : pos + PW'(1);
            end
            M_LEFT: begin
                dir_nxt = 1'b1;
                if (tick) pos_nxt = (pos == '0) ? POS_LAST : pos - PW'(1);
            end
            M_BOUNCE: begin
                if (tick) begin
                    if (!dir) begin
                        if (pos < BOUNCE_MAX) begin
                            pos_nxt = pos + PW'(1);
                        end else begin
                            dir_nxt = 1'b1;
                            pos_nxt = pos - PW'(1);
                        end
                    end else begin
                        if (pos > '0) begin
                            pos_nxt = pos - PW'(1);
                        end else begin
                            dir_nxt = 1'b0;
                            pos_nxt = PW'(1);
                        end
                    end
                end
            end
            default: begin
`ifdef MARQUEE_BLINK_EN
                blink_nxt = tick ? ~blink : blink;
`endif
            end
        endcase
    end

    // The display register is loaded from the next position so it moves together with pos.
    always_comb begin
`ifdef MARQUEE_BLINK_EN
        bcd_nxt = blink_nxt ? '1 : render(pos_nxt);
`else
        bcd_nxt = render(pos_nxt);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
            dir <= 1'b0;
            bcd <= render('0);
        end else begin
            pos <= pos_nxt;
            dir <= dir_nxt;
            bcd <= bcd_nxt;
        end
    end

`ifdef MARQUEE_BLINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blink <= 1'b0;
        else     blink <= blink_nxt;
    end
`endif

endmodule

// File: tb/tb_marquee_ctrl.sv
// Self-checking bench for marquee_ctrl: spec vector table, corner sequences, random vs. model.
// Blink expectations follow MARQUEE_BLINK_EN when it is defined for the build.
module tb_marquee_ctrl;

    localparam int D  = 4;
    localparam int PL = 2;
    localparam int TD = 50;
    localparam logic [4*PL-1:0] PAT = {4'd2, 4'd5};

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [1:0]     mode;
    logic [4*D-1:0] bcd;
    logic [2:0]     led;
    logic           tick;

    marquee_ctrl #(.DIGITS(D), .PAT_LEN(PL), .PATTERN(PAT), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .bcd(bcd), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_ticks = 0;

    // Reference state: pattern offset, bounce direction, divider count, blink phase.
    int m_cnt = 0;
    int m_pos = 0;
    bit m_dir = 1'b0;
    bit m_ph  = 1'b0;

    typedef struct {
        logic [1:0]     mode;
        logic [4*D-1:0] bcd;
        logic [2:0]     led;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_led(input logic [1:0] m);
        case (m)
            2'b00:   return 3'b100;
            2'b01:   return 3'b010;
            2'b10:   return 3'b001;
            default: return 3'b110;
        endcase
    endfunction

    // Place each pattern digit at its slot; everything else is blank.
    function automatic logic [4*D-1:0] exp_bcd();
        logic [4*D-1:0] r;
        logic [4*PL-1:0] p;
        int slot;
        r = '1;
        p = PAT;
        if (m_ph) return r;
        for (int k = 0; k < PL; k++) begin
            slot = (m_pos + k) % D;
            r[4*(D-1-slot) +: 4] = p[4*(PL-1-k) +: 4];
        end
        return r;
    endfunction

    task automatic model_edge(input bit tk);
        if (rst) begin
            m_cnt = 0; m_pos = 0; m_dir = 1'b0; m_ph = 1'b0;
            return;
        end
        if (en) m_cnt = (m_cnt == TD-1) ? 0 : m_cnt + 1;
        case (mode)
            2'b00: begin
                m_dir = 1'b0;
                if (tk) m_pos = (m_pos + 1) % D;
            end
            2'b10: begin
                m_dir = 1'b1;
                if (tk) m_pos = (m_pos + D - 1) % D;
            end
            2'b01: begin
                if (tk) begin
                    if (!m_dir) begin
                        if (m_pos < D - PL) m_pos++;
                        else begin m_dir = 1'b1; m_pos--; end
                    end else begin
                        if (m_pos > 0) m_pos--;
                        else begin m_dir = 1'b0; m_pos = 1; end
                    end
                end
            end
            default: ;
        endcase
`ifdef MARQUEE_BLINK_EN
        m_ph = (mode == 2'b11) ? (tk ? ~m_ph : m_ph) : 1'b0;
`endif
    endtask

    // One clock: check tick/led before the edge, advance the model, check bcd after it.
    task automatic step(output bit tk);
        #1;
        tk = en && !rst && (m_cnt == TD-1);
        if (tick) dut_ticks++;
        check("tick", {31'd0, tick}, {31'd0, tk});
        check("led", {29'd0, led}, {29'd0, exp_led(mode)});
        @(posedge clk);
        model_edge(tk);
        #1;
        check("bcd", {16'd0, bcd}, {16'd0, exp_bcd()});
    endtask

    task automatic run_to_tick(input string name, output int n);
        bit t;
        t = 1'b0;
        n = 0;
        while (!t && n < 2*TD) begin
            step(t);
            n++;
        end
        check({name, "_tick_seen"}, {31'd0, t}, 32'd1);
    endtask

    vec_t tab [20];
    vec_t rel [4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   t;
        int   n;
        int   t0;
        logic [1:0] rmodes [4];

        tab[0]  = '{2'b00, 16'hF25F, 3'b100};
        tab[1]  = '{2'b00, 16'hFF25, 3'b100};
        tab[2]  = '{2'b00, 16'h5FF2, 3'b100};
        tab[3]  = '{2'b00, 16'h25FF, 3'b100};
        tab[4]  = '{2'b00, 16'hF25F, 3'b100};
        tab[5]  = '{2'b01, 16'hFF25, 3'b010};
        tab[6]  = '{2'b01, 16'hF25F, 3'b010};
        tab[7]  = '{2'b01, 16'h25FF, 3'b010};
        tab[8]  = '{2'b01, 16'hF25F, 3'b010};
        tab[9]  = '{2'b00, 16'hFF25, 3'b100};
        tab[10] = '{2'b00, 16'h5FF2, 3'b100};
        tab[11] = '{2'b01, 16'hFF25, 3'b010};
        tab[12] = '{2'b01, 16'hF25F, 3'b010};
        tab[13] = '{2'b01, 16'h25FF, 3'b010};
        tab[14] = '{2'b10, 16'h5FF2, 3'b001};
        tab[15] = '{2'b10, 16'hFF25, 3'b001};
        tab[16] = '{2'b10, 16'hF25F, 3'b001};
        tab[17] = '{2'b10, 16'h25FF, 3'b001};
`ifdef MARQUEE_BLINK_EN
        tab[18] = '{2'b11, 16'hFFFF, 3'b110};
`else
        tab[18] = '{2'b11, 16'h25FF, 3'b110};
`endif
        tab[19] = '{2'b11, 16'h25FF, 3'b110};

        rel[0] = '{2'b01, 16'hF25F, 3'b010};
        rel[1] = '{2'b01, 16'hFF25, 3'b010};
        rel[2] = '{2'b01, 16'hF25F, 3'b010};
        rel[3] = '{2'b01, 16'h25FF, 3'b010};

        rmodes[0] = 2'b00; rmodes[1] = 2'b10; rmodes[2] = 2'b11; rmodes[3] = 2'b01;

        // Reset state
        rst = 1'b1; en = 1'b1; mode = 2'b00;
        #1;
        check("rst_bcd", {16'd0, bcd}, 32'h25FF);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_led", {29'd0, led}, 32'b100);
        repeat (3) step(t);
        rst = 1'b0;

        // Spec walk-through: scroll right, bounce, wrapped bounce, scroll left, hold
        for (int i = 0; i < 20; i++) begin
            mode = tab[i].mode;
            #1;
            check($sformatf("tab%0d_led", i), {29'd0, led}, {29'd0, tab[i].led});
            run_to_tick($sformatf("tab%0d", i), n);
            if (i == 0) check("first_tick_clocks", n, TD);
            check($sformatf("tab%0d_bcd", i), {16'd0, bcd}, {16'd0, tab[i].bcd});
        end

        // Reset in mid-bounce with mode toggling during reset
        mode = 2'b01;
        run_to_tick("pre_rst_a", n);
        run_to_tick("pre_rst_b", n);
        repeat (7) step(t);
        rst = 1'b1;
        #1;
        check("midrst_bcd", {16'd0, bcd}, 32'h25FF);
        check("midrst_tick", {31'd0, tick}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mode = rmodes[i];
            #1;
            check($sformatf("midrst_led%0d", i), {29'd0, led}, {29'd0, exp_led(rmodes[i])});
            step(t);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = rel[i].mode;
            run_to_tick($sformatf("rel%0d", i), n);
            if (i == 0) check("rel_first_tick_clocks", n, TD);
            check($sformatf("rel%0d_bcd", i), {16'd0, bcd}, {16'd0, rel[i].bcd});
        end

        // Frozen divider: no ticks, display held
        mode = 2'b00;
        en = 1'b0;
        t0 = dut_ticks;
        repeat (3*TD) step(t);
        check("frozen_ticks", dut_ticks - t0, 0);
        check("frozen_bcd", {16'd0, bcd}, 32'h25FF);
        en = 1'b1;

        // Hold mode across several ticks
        mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_to_tick($sformatf("hold%0d", i), n);
`ifdef MARQUEE_BLINK_EN
            check($sformatf("hold%0d_bcd", i), {16'd0, bcd}, (i % 2 == 0) ? 32'hFFFF : 32'h25FF);
`else
            check($sformatf("hold%0d_bcd", i), {16'd0, bcd}, 32'h25FF);
`endif
        end

        // Random segments against the reference model
        for (int s = 0; s < 250; s++) begin
            mode = 2'($urandom_range(0, 3));
            en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat (2) step(t);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 2*TD)) step(t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/marquee_ctrl.md
MARQUEE_CTRL -- requirements
Module: marquee_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 7-seg digit positions (legal 2..8).
REQ-002 SHALL have parameter PAT_LEN, default 2, number of pattern digits (legal 1..DIGITS-1).
REQ-003 SHALL have parameter PATTERN, width 4*PAT_LEN, default {4'd2,4'd5}; the MS nibble is the first (leftmost) pattern digit.
REQ-004 SHALL have parameter TICK_DIV, default 50, clocks per movement step (legal >=2).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  1  tick-counter enable; 0 freezes the counter and all movement.
REQ-008 SHALL have port mode  input  2  00 scroll-right, 01 bounce, 10 scroll-left, 11 hold.
REQ-009 SHALL have port bcd  output  4*DIGITS  digit codes; MS nibble is the leftmost digit; 4'hF means blank.
REQ-010 SHALL have port led  output  3  mode indicator.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each movement step.

Function
REQ-012 SHALL run a counter from 0 to TICK_DIV-1 and wrap it to 0 while en=1; tick=1 in the cycle where the count is TICK_DIV-1 and en=1.
REQ-013 SHALL hold pos (0..DIGITS-1, the leftmost pattern digit position) and dir (0=right, 1=left), both registered.
REQ-014 SHALL, on tick in mode 00, set pos to pos+1, or to 0 when pos=DIGITS-1.
REQ-015 SHALL, on tick in mode 10, set pos to pos-1, or to DIGITS-1 when pos=0.
REQ-016 SHALL force dir to 0 on every clock while mode=00 and to 1 on every clock while mode=10, independent of tick.
REQ-017 SHALL, on tick in mode 01 with dir=0: if pos<DIGITS-PAT_LEN, set pos to pos+1; otherwise set dir to 1 and pos to pos-1.
REQ-018 SHALL, on tick in mode 01 with dir=1: if pos>0, set pos to pos-1; otherwise set dir to 0 and pos to 1.
REQ-019 SHALL, in mode 11, keep pos and dir unchanged; the counter and tick continue.
REQ-020 SHALL, on a mode change, not alter pos or the counter; the new mode takes effect from the next tick.
REQ-021 SHALL, for display digit i (0 = leftmost), output PATTERN digit k when (i-pos) mod DIGITS = k < PAT_LEN, else 4'hF; wrapped patterns split across the right and left edges.
REQ-022 SHALL decode led combinationally from mode, also during reset: 00->3'b100, 01->3'b010, 10->3'b001, 11->3'b110.
REQ-023 SHALL register bcd so that it changes in the cycle after the tick that moved pos.

Reset
REQ-024 SHALL, while rst=1, asynchronously set the counter to 0, pos to 0, dir to 0 and the blink phase to 0, and hold tick=0.
REQ-025 SHALL, while rst=1, output bcd equal to PATTERN at the leftmost positions with the rest blank; for the defaults this is 16'h25FF.
REQ-026 SHALL, after rst is released, produce the first tick TICK_DIV clocks later, with en=1.

Configuration
REQ-027 SHALL, when MARQUEE_BLINK_EN is defined, toggle a blink phase on each tick in mode 11 and drive bcd all 4'hF while the phase is 1; the phase clears on leaving mode 11.
REQ-028 SHALL, when MARQUEE_BLINK_EN is undefined, show a static pattern in mode 11 and implement no blink logic.

Verification
REQ-029 SHALL cover: reset, then mode=00 with defaults -> bcd 25FF, F25F, FF25, 5FF2, 25FF at successive ticks; led=100.
REQ-030 SHALL cover: from F25F switch to mode=01 -> led=010 immediately; bcd F25F, then FF25, F25F, 25FF, F25F at successive ticks.
REQ-031 SHALL cover: at 5FF2 in mode 00 switch to mode=01 -> FF25, F25F, 25FF at successive ticks, since dir reverses at the wrapped position.
REQ-032 SHALL cover: mode=10 from reset -> 5FF2, FF25, F25F, 25FF; led=001.
REQ-033 SHALL cover: assert rst mid-bounce, toggle mode during reset -> bcd=25FF and led tracks mode; after release in mode 01 -> F25F, FF25, F25F, 25FF.
REQ-034 SHALL cover: en=0 for 3*TICK_DIV clocks -> no tick and bcd frozen; mode=11 with MARQUEE_BLINK_EN -> bcd alternates pattern and FFFF each tick.
